// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// default bus-timeout length and the timeout counter width helper.
package fetch_pkg;

  localparam int unsigned TMO_DEFAULT = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_INC  = 3'd3,
    S_HOLD = 3'd4,
    S_JUMP = 3'd5
  } fetch_state_e;

  function automatic int unsigned tmo_width(input int unsigned tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/fetch_tmo.sv
// WAIT-phase timeout counter: cleared while i_clr, counts while i_cnt_en,
// o_expired is high during the TMO-th counted cycle (no backpressure).
module fetch_tmo
  import fetch_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_cnt_en,
  output logic o_expired
);

  localparam int unsigned   W    = tmo_width(TMO);
  localparam logic [W-1:0]  LAST = W'(TMO - 1);

  logic [W-1:0] r_cnt;

  // Saturates on LAST so a stalled enable never wraps back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_cnt_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_cnt_en && (r_cnt == LAST);

endmodule

// File: rtl/fetch_ctl.sv
// Byte fetch sequencer between program counter, memory and instruction consumer.
// Accepted fetches recur every 4 cycles; HOLD stalls on ir_ready, WAIT times out after TMO.
module fetch_ctl
  import fetch_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pc_ao,
  output logic [15:0] pc_ai,
  output logic        pc_lrc,
  output logic        pc_ini,
  output logic        pc_oe,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  ir_data,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        jmp_req,
  input  logic [15:0] jmp_addr,
  output logic        jmp_ack,
  output logic        err
);

  fetch_state_e r_state;
  fetch_state_e w_next;
  logic [7:0]   r_ir_data;
  logic         r_err;
  logic         w_in_wait;
  logic         w_expired;
  logic         w_capture;
  logic         w_timeout;

  assign w_in_wait = (r_state == S_WAIT);

  // Held clear outside WAIT, so every entry into WAIT starts from zero.
  fetch_tmo #(.TMO(TMO)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_in_wait),
    .i_cnt_en  (w_in_wait),
    .o_expired (w_expired)
  );

  assign w_capture = w_in_wait && mem_ack;
  assign w_timeout = w_in_wait && !mem_ack && w_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir_data <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_ir_data <= mem_rdata;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (jmp_req) begin
          w_next = S_JUMP;
        end else if (en && !r_err) begin
          w_next = S_ADDR;
        end
      end
      S_ADDR: w_next = S_WAIT;
      S_WAIT: begin
        // An ack landing on the expiry cycle still wins over the timeout.
        if (mem_ack) begin
          w_next = S_INC;
        end else if (w_expired) begin
          w_next = S_IDLE;
        end
      end
      S_INC:  w_next = S_HOLD;
      S_HOLD: begin
        if (jmp_req) begin
          w_next = S_JUMP;
        end else if (ir_ready) begin
          w_next = en ? S_ADDR : S_IDLE;
        end
      end
      S_JUMP:  w_next = en ? S_ADDR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_oe    = 1'b0;
    mem_req  = 1'b0;
    pc_ini   = 1'b0;
    pc_lrc   = 1'b0;
    jmp_ack  = 1'b0;
    ir_valid = 1'b0;
    case (r_state)
      S_ADDR, S_WAIT: begin
        pc_oe   = 1'b1;
        mem_req = 1'b1;
      end
      S_INC:  pc_ini = 1'b1;
      S_HOLD: ir_valid = 1'b1;
      S_JUMP: begin
        pc_lrc  = 1'b1;
        jmp_ack = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr = mem_req ? pc_ao : 16'h0000;
  assign pc_ai    = pc_lrc ? jmp_addr : 16'h0000;
  assign ir_data  = r_ir_data;
  assign err      = r_err;

  a_pc_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(pc_lrc && pc_ini));

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_HOLD && !ir_ready && !jmp_req) |=> (r_state == S_HOLD && $stable(r_ir_data)));

endmodule

// File: tb/tb_fetch_ctl.sv
`timescale 1ns/1ps
module tb_fetch_ctl;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] pc_ao = 16'h0000;
  logic [15:0] pc_ai;
  logic        pc_lrc;
  logic        pc_ini;
  logic        pc_oe;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  ir_data;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        jmp_req = 1'b0;
  logic [15:0] jmp_addr = 16'h0000;
  logic        jmp_ack;
  logic        err;

  fetch_ctl #(.TMO(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_ao(pc_ao), .pc_ai(pc_ai),
    .pc_lrc(pc_lrc), .pc_ini(pc_ini), .pc_oe(pc_oe), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_data(ir_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .jmp_req(jmp_req), .jmp_addr(jmp_addr), .jmp_ack(jmp_ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];
  logic mem_auto = 1'b0;
  int ack_delay = 0;
  int req_cnt = 0;
  int pc_ini_cnt = 0;
  int jmp_ack_cnt = 0;
  int req_cycles = 0;
  int acc_cnt = 0;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hBC;
  endfunction

  // Memory model: the first mem_req cycle is ADDR, ack lands ack_delay cycles into WAIT.
  always @(negedge clk) begin
    if (mem_req) req_cnt = req_cnt + 1;
    else req_cnt = 0;
    if (mem_req && mem_auto && (req_cnt == 2 + ack_delay)) begin
      mem_ack = 1'b1;
      mem_rdata = mem_byte(mem_addr);
      sb.push_back(mem_rdata);
    end else begin
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
    end
  end

  // Monitor just before each rising edge; also models the program counter.
  always @(negedge clk) begin
    logic [15:0] nxt;
    logic [7:0]  exp_b;
    #4;
    nxt = pc_ao;
    if (rst) begin
      n_checks++;
      if (mem_addr !== (mem_req ? pc_ao : 16'h0000)) begin
        n_errors++;
        $display("FAIL mon_mem_addr: got %h, expected %h", mem_addr, mem_req ? pc_ao : 16'h0000);
      end
      n_checks++;
      if (pc_ai !== (pc_lrc ? jmp_addr : 16'h0000)) begin
        n_errors++;
        $display("FAIL mon_pc_ai: got %h, expected %h", pc_ai, pc_lrc ? jmp_addr : 16'h0000);
      end
      n_checks++;
      if (pc_lrc && pc_ini) begin
        n_errors++;
        $display("FAIL mon_pc_excl: pc_lrc=%b pc_ini=%b, expected not both 1", pc_lrc, pc_ini);
      end
      if (ir_valid && jmp_req) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (ir_valid && ir_ready) begin
        acc_cnt++;
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL sb_empty: ir_data=%h accepted, expected no byte", ir_data);
        end else begin
          exp_b = sb.pop_front();
          if (ir_data !== exp_b) begin
            n_errors++;
            $display("FAIL sb_data: ir_data=%h, expected %h", ir_data, exp_b);
          end
        end
      end
      if (pc_ini) pc_ini_cnt++;
      if (jmp_ack) jmp_ack_cnt++;
      if (mem_req) req_cycles++;
      if (pc_lrc) nxt = pc_ai;
      else if (pc_ini) nxt = pc_ao + 16'd1;
    end
    #2;
    pc_ao = nxt;
  end

  task automatic do_reset(input logic [15:0] start_pc);
    mem_auto = 1'b0;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; ir_ready = 1'b0; jmp_req = 1'b0; jmp_addr = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    pc_ao = start_pc;
    pc_ini_cnt = 0; jmp_ack_cnt = 0; req_cycles = 0; acc_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_req, pc_oe, pc_ini, pc_lrc, jmp_ack, ir_valid, err} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: {req,oe,ini,lrc,ack,valid,err}=%b, expected 0", {mem_req, pc_oe, pc_ini, pc_lrc, jmp_ack, ir_valid, err});
    end
    n_checks++;
    if ({ir_data, pc_ai, mem_addr} !== 40'h0) begin
      n_errors++;
      $display("FAIL reset_data: ir_data=%h pc_ai=%h mem_addr=%h, expected 0", ir_data, pc_ai, mem_addr);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_cycles != 0 || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle_en0: req_cycles=%0d, expected 0", req_cycles);
    end
  endtask

  task automatic test_first_fetch();
    do_reset(16'h8000);
    en = 1'b1; mem_auto = 1'b1; ack_delay = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || pc_oe !== 1'b1 || mem_addr !== 16'h8000) begin
      n_errors++;
      $display("FAIL ff_c1_addr: mem_req=%b pc_oe=%b mem_addr=%h, expected 1 1 8000", mem_req, pc_oe, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || ir_valid !== 1'b0 || pc_ini !== 1'b0) begin
      n_errors++;
      $display("FAIL ff_c2_wait: mem_req=%b ir_valid=%b pc_ini=%b, expected 1 0 0", mem_req, ir_valid, pc_ini);
    end
    @(negedge clk);
    n_checks++;
    if (pc_ini !== 1'b1 || ir_data !== 8'h3C || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL ff_c3_inc: pc_ini=%b ir_data=%h mem_req=%b, expected 1 3c 0", pc_ini, ir_data, mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (ir_valid !== 1'b1 || ir_data !== 8'h3C || pc_ini_cnt != 1) begin
      n_errors++;
      $display("FAIL ff_c4_hold: ir_valid=%b ir_data=%h pc_ini_cnt=%0d, expected 1 3c 1", ir_valid, ir_data, pc_ini_cnt);
    end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ir_valid, ir_data, mem_req, pc_ini} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin
        n_errors++;
        $display("FAIL hold_stall[%0d]: valid=%b data=%h req=%b ini=%b, expected 1 3c 0 0", i, ir_valid, ir_data, mem_req, pc_ini);
      end
    end
    n_checks++;
    if (pc_ini_cnt != 1 || req_cycles != 2) begin
      n_errors++;
      $display("FAIL hold_counts: pc_ini_cnt=%0d req_cycles=%0d, expected 1 2", pc_ini_cnt, req_cycles);
    end
  endtask

  task automatic test_en_drop();
    int rc;
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ir_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL endrop_hold: ir_valid=%b, expected 1", ir_valid);
    end
    ir_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL endrop_idle: ir_valid=%b mem_req=%b, expected 0 0", ir_valid, mem_req);
    end
    rc = req_cycles;
    repeat (6) @(negedge clk);
    n_checks++;
    if (req_cycles != rc || acc_cnt != 1 || sb.size() != 0) begin
      n_errors++;
      $display("FAIL endrop_quiet: req_cycles=%0d acc=%0d sb=%0d, expected %0d 1 0", req_cycles, acc_cnt, sb.size(), rc);
    end
    ir_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs[4];
    int vcyc[4];
    int na = 0;
    int nv = 0;
    logic prev_req = 1'b0;
    logic [15:0] exp_a;
    do_reset(16'hFFFE);
    en = 1'b1; ir_ready = 1'b1; mem_auto = 1'b1; ack_delay = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 40 && nv < 4; cyc++) begin
      @(negedge clk);
      if (mem_req && !prev_req && na < 4) begin
        addrs[na] = mem_addr;
        na++;
      end
      prev_req = mem_req;
      if (ir_valid) begin
        vcyc[nv] = cyc;
        nv++;
        if (nv == 4) en = 1'b0;
      end
    end
    n_checks++;
    if (nv != 4 || na != 4) begin
      n_errors++;
      $display("FAIL b2b_count: valids=%0d fetches=%0d, expected 4 4", nv, na);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_a = 16'hFFFE + 16'(i);
        n_checks++;
        if (addrs[i] !== exp_a) begin
          n_errors++;
          $display("FAIL b2b_addr[%0d]: mem_addr=%h, expected %h", i, addrs[i], exp_a);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (vcyc[i] - vcyc[i-1] != 4) begin
          n_errors++;
          $display("FAIL b2b_period[%0d]: %0d cycles, expected 4", i, vcyc[i] - vcyc[i-1]);
        end
      end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (pc_ini_cnt != 4 || acc_cnt != 4 || sb.size() != 0 || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_end: pc_ini_cnt=%0d acc=%0d sb=%0d req=%b, expected 4 4 0 0", pc_ini_cnt, acc_cnt, sb.size(), mem_req);
    end
  endtask

  task automatic test_jump();
    logic seen_hold = 1'b0;
    logic got_ack = 1'b0;
    do_reset(16'h1230);
    en = 1'b1; mem_auto = 1'b1; ack_delay = 2; ir_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    jmp_req = 1'b1; jmp_addr = 16'h800A;
    for (int i = 0; i < 12 && !got_ack; i++) begin
      @(negedge clk);
      if (ir_valid) seen_hold = 1'b1;
      if (jmp_ack) begin
        got_ack = 1'b1;
        n_checks++;
        if (pc_ai !== 16'h800A || pc_lrc !== 1'b1 || seen_hold !== 1'b1 || pc_ini_cnt != 1) begin
          n_errors++;
          $display("FAIL jump_state: pc_ai=%h lrc=%b hold_seen=%b pc_ini_cnt=%0d, expected 800a 1 1 1", pc_ai, pc_lrc, seen_hold, pc_ini_cnt);
        end
        jmp_req = 1'b0;
      end
    end
    n_checks++;
    if (!got_ack) begin
      n_errors++;
      $display("FAIL jump_timeout: jmp_ack=0 after 12 cycles, expected pulse");
    end
    @(negedge clk);
    n_checks++;
    if (jmp_ack !== 1'b0 || pc_lrc !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h800A || jmp_ack_cnt != 1) begin
      n_errors++;
      $display("FAIL jump_next: ack=%b lrc=%b req=%b addr=%h acks=%0d, expected 0 0 1 800a 1", jmp_ack, pc_lrc, mem_req, mem_addr, jmp_ack_cnt);
    end
    en = 1'b0; ir_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (acc_cnt != 1 || sb.size() != 0 || pc_ini_cnt != 2) begin
      n_errors++;
      $display("FAIL jump_refetch: acc=%0d sb=%0d pc_ini_cnt=%0d, expected 1 0 2", acc_cnt, sb.size(), pc_ini_cnt);
    end
  endtask

  task automatic test_timeout();
    int rc;
    logic got_err = 1'b0;
    do_reset(16'h4000);
    en = 1'b1; mem_auto = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40 && !got_err; i++) begin
      @(negedge clk);
      if (err === 1'b1) got_err = 1'b1;
    end
    n_checks++;
    if (!got_err || req_cycles != 1 + TMO) begin
      n_errors++;
      $display("FAIL tmo_len: err=%b req_cycles=%0d, expected 1 %0d", got_err, req_cycles, 1 + TMO);
    end
    n_checks++;
    if (mem_req !== 1'b0 || ir_valid !== 1'b0 || pc_ini_cnt != 0 || ir_data !== 8'h00) begin
      n_errors++;
      $display("FAIL tmo_idle: req=%b valid=%b pc_ini_cnt=%0d ir_data=%h, expected 0 0 0 00", mem_req, ir_valid, pc_ini_cnt, ir_data);
    end
    rc = req_cycles;
    repeat (20) @(negedge clk);
    n_checks++;
    if (req_cycles != rc || err !== 1'b1) begin
      n_errors++;
      $display("FAIL tmo_sticky: req_cycles=%0d err=%b, expected %0d 1", req_cycles, err, rc);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_clear: err=%b after reset, expected 0", err);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(16'h2000);
    en = 1'b1; mem_auto = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL rmw_pre: mem_req=%b, expected 1", mem_req);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, pc_oe, pc_ini, pc_lrc, err, ir_valid} !== 6'b0 || mem_addr !== 16'h0000) begin
      n_errors++;
      $display("FAIL rmw_async: {req,oe,ini,lrc,err,valid}=%b addr=%h, expected 0", {mem_req, pc_oe, pc_ini, pc_lrc, err, ir_valid}, mem_addr);
    end
    repeat (3) @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (pc_ini_cnt != 0 || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL rmw_after: pc_ini_cnt=%0d req=%b, expected 0 0", pc_ini_cnt, mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_en_drop();
    test_back_to_back();
    test_jump();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
